line_memory: RTL and testbench
==============================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word address width.
REQ-002 SHALL have parameter WORD_W, default 32, bits per word.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, words per cache line; power of two, >=2.
REQ-004 SHALL have parameter DEPTH, default 32000, number of implemented words; multiple of WORDS_PER_LINE, <= 2^ADDR_W.
REQ-005 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; >=1.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  module can accept a request.
REQ-010 SHALL have port req_we  input  1  1 = line write, 0 = line read.
REQ-011 SHALL have port req_addr  input  ADDR_W  word address; low log2(WORDS_PER_LINE) bits ignored.
REQ-012 SHALL have port wr_line  input  WORD_W*WORDS_PER_LINE  write data.
REQ-013 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-014 SHALL have port resp_err  output  1  request was out of range; valid with resp_valid.
REQ-015 SHALL have port rd_line  output  WORD_W*WORDS_PER_LINE  read data; valid with resp_valid.

Function
REQ-016 SHALL implement a storage array of DEPTH words of WORD_W bits.
REQ-017 SHALL form line base = req_addr with low log2(WORDS_PER_LINE) bits forced to 0.
REQ-018 SHALL map word base+i to bits [WORD_W*i +: WORD_W] of rd_line/wr_line, i = 0..WORDS_PER_LINE-1.
REQ-019 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on the edge where req_valid && req_ready; capture req_we, base, wr_line; go IDLE->BUSY; load latency counter with LATENCY-1.
REQ-021 SHALL, in BUSY with counter != 0, decrement counter and stay in BUSY.
REQ-022 SHALL, in BUSY with counter == 0, perform the access on that edge, set resp_valid=1, go to RESP.
REQ-023 SHALL, in RESP, clear resp_valid and go to IDLE on the next edge; resp_valid is high exactly one cycle, no backpressure.
REQ-024 SHALL give resp_valid high in the cycle beginning LATENCY edges after the acceptance edge; minimum request spacing LATENCY+2 cycles.
REQ-025 SHALL, on an in-range write (base < DEPTH), write all WORDS_PER_LINE words atomically on the REQ-022 edge; rd_line = 0 for writes.
REQ-026 SHALL, on an in-range read, drive rd_line with array contents at the REQ-022 edge, holding it until next response.
REQ-027 SHALL treat base >= DEPTH as out of range: resp_err=1, rd_line=0, no array write; response timing unchanged.
REQ-028 SHALL ignore req_valid, req_we, req_addr, wr_line while not in IDLE; captured values are not altered by input changes.
REQ-029 SHALL, for a read after a write to the same line, return the written data (write visible from the edge after commit).

Reset
REQ-030 SHALL, on a rising edge with rst=0, force state IDLE, counter 0, resp_valid 0, resp_err 0, rd_line 0; req_ready=1 from the following cycle.
REQ-031 SHALL, on reset in BUSY, abort the request: no write committed, no response issued.
REQ-032 SHALL, on reset coinciding with the REQ-022 edge, have reset win: no write, resp_valid stays 0.
REQ-033 SHALL NOT clear or initialise storage contents on reset.

Verification
REQ-034 Write addr 0x0010, wr_line words {0xA0,0xA1,0xA2,0xA3} (word0 lowest), then read addr 0x0013 -> resp_valid 2 cycles after each acceptance, rd_line words {0xA0,0xA1,0xA2,0xA3}, resp_err 0.
REQ-035 Read addr 32000 (DEFAULTS) -> resp_valid with resp_err 1, rd_line 0; subsequent read of 0x0010 unchanged.
REQ-036 Hold req_valid=1 continuously with changing req_addr -> acceptances exactly every 4 cycles, each response matching address captured at acceptance.
REQ-037 Write 0xFF.. to line 0x0020, assert rst=0 one cycle after acceptance, then read 0x0020 -> no resp_valid for the write; read returns prior contents.
REQ-038 Rerun REQ-034 with LATENCY=1, WORDS_PER_LINE=8, WORD_W=16 -> response 1 cycle after acceptance, 8 words ordered per REQ-018.

Source files
------------

// File: rtl/line_memory.sv
// ---------------------------------------------------------------------------
// line_memory
//   Line-granular storage with a fixed, parameterisable access latency.
//   One request is accepted at a time while idle; after LATENCY edges a
//   whole line is written or read and a single-cycle response is issued.
//   Addresses at or beyond DEPTH are answered with an error and touch
//   nothing. Storage is never cleared by reset.
//
//   State table
//     IDLE | ready for a request (req_ready = 1)
//     BUSY | request captured, latency counter running down
//     RESP | resp_valid high for this single cycle
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous reset, active low
//   req_valid  : request present
//   req_ready  : request can be accepted (IDLE only)
//   req_we     : 1 = line write, 0 = line read
//   req_addr   : word address; line-offset bits are ignored
//   wr_line    : write data, word i at [WORD_W*i +: WORD_W]
//   resp_valid : one-cycle response pulse
//   resp_err   : request was out of range (qualified by resp_valid)
//   rd_line    : read data (qualified by resp_valid, held until next response)
// ---------------------------------------------------------------------------
module line_memory #(
  parameter int ADDR_W         = 15,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int DEPTH          = 32000,
  parameter int LATENCY        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] wr_line,
  output logic                             resp_valid,
  output logic                             resp_err,
  output logic [WORD_W*WORDS_PER_LINE-1:0] rd_line
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINES  = DEPTH / WORDS_PER_LINE;
  localparam int LIDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Storage is organised as whole lines so a line write is a single,
  // atomic array update; word i of a line sits at [WORD_W*i +: WORD_W].
  logic [LINE_W-1:0] r_mem [0:LINES-1];

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [LINE_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [LINE_W-1:0] r_rd_line;

  logic              w_in_range;
  logic              w_commit;
  logic [LIDX_W-1:0] w_lidx;

  assign w_in_range = ({1'b0, r_base} < DEPTH_C);
  assign w_commit   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_lidx     = r_base[OFF_W +: LIDX_W];

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign rd_line    = r_rd_line;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_line    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            // masking (rather than slicing) keeps every address bit in use
            r_base  <= req_addr & ~OFF_MASK;
            r_wdata <= wr_line;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_in_range;
            r_rd_line    <= (!r_we && w_in_range) ? r_mem[w_lidx] : '0;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array write on the commit edge; a coincident reset cancels it.
  always_ff @(posedge clk) begin
    if (rst && w_commit && r_we && w_in_range) begin
      r_mem[w_lidx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
module tb_line_memory;

  logic clk;
  logic rst;

  // DUT A: default parameters (LATENCY 2, 4 x 32-bit words)
  logic         a_valid, a_ready, a_we, a_rv, a_err;
  logic [14:0]  a_addr;
  logic [127:0] a_wr, a_rd;

  // DUT B: LATENCY 1, 8 x 16-bit words
  logic         b_valid, b_ready, b_we, b_rv, b_err;
  logic [14:0]  b_addr;
  logic [127:0] b_wr, b_rd;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] DATA_A = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] DATA_K1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] DATA_K2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] DATA_B = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;

  line_memory u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .wr_line(a_wr),
    .resp_valid(a_rv), .resp_err(a_err), .rd_line(a_rd)
  );

  line_memory #(
    .ADDR_W(15), .WORD_W(16), .WORDS_PER_LINE(8), .DEPTH(32000), .LATENCY(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .wr_line(b_wr),
    .resp_valid(b_rv), .resp_err(b_err), .rd_line(b_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference contents of the lines the bench uses: {err, data}
  function automatic logic [128:0] model_a(input logic [14:0] addr);
    logic [14:0] base;
    base = {addr[14:2], 2'b00};
    if (base >= 15'd32000) return {1'b1, 128'h0};
    case (base)
      15'h0010: return {1'b0, DATA_A};
      15'h0020: return {1'b0, DATA_K1};
      15'd31996: return {1'b0, DATA_K2};
      default: return {1'b0, 128'h0};
    endcase
  endfunction

  // One request on DUT A, checking the 2-cycle response timing.
  task automatic req_a(input string tag, input logic we, input logic [14:0] addr,
                       input logic [127:0] data, input logic [127:0] exp_rd, input logic exp_err);
    @(negedge clk);
    chk({tag, " ready"}, a_ready, 1);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wr = data;
    @(posedge clk); #1;
    // disturb inputs while busy; none of this may reach the access
    a_valid = 1'b0; a_we = ~we; a_addr = addr ^ 15'h0044; a_wr = ~data;
    chk({tag, " busy_ready"}, a_ready, 0);
    chk({tag, " rv_e0"}, a_rv, 0);
    @(posedge clk); #1;
    chk({tag, " rv_e1"}, a_rv, 0);
    @(posedge clk); #1;
    chk({tag, " rv"}, a_rv, 1);
    chk({tag, " err"}, a_err, 128'(exp_err));
    chk({tag, " rd"}, a_rd, exp_rd);
    @(posedge clk); #1;
    chk({tag, " rv_done"}, a_rv, 0);
    chk({tag, " rd_hold"}, a_rd, exp_rd);
    chk({tag, " ready_back"}, a_ready, 1);
  endtask

  // One request on DUT B, checking the 1-cycle response timing.
  task automatic req_b(input string tag, input logic we, input logic [14:0] addr,
                       input logic [127:0] data, input logic [127:0] exp_rd, input logic exp_err);
    @(negedge clk);
    chk({tag, " ready"}, b_ready, 1);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wr = data;
    @(posedge clk); #1;
    b_valid = 1'b0; b_we = ~we; b_addr = addr ^ 15'h0044; b_wr = ~data;
    chk({tag, " rv_e0"}, b_rv, 0);
    @(posedge clk); #1;
    chk({tag, " rv"}, b_rv, 1);
    chk({tag, " err"}, b_err, 128'(exp_err));
    chk({tag, " rd"}, b_rd, exp_rd);
    @(posedge clk); #1;
    chk({tag, " rv_done"}, b_rv, 0);
    chk({tag, " ready_back"}, b_ready, 1);
  endtask

  initial begin
    logic [14:0]  pat [5];
    logic [14:0]  acc_addr;
    logic [128:0] m;

    rst = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wr = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wr = '0;
    acc_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst a_rv", a_rv, 0);
    chk("rst a_err", a_err, 0);
    chk("rst a_rd", a_rd, 0);
    chk("rst a_ready", a_ready, 1);
    chk("rst b_rv", b_rv, 0);
    chk("rst b_rd", b_rd, 0);
    @(negedge clk);
    rst = 1'b1;

    // known contents
    req_a("wr_k1", 1'b1, 15'h0020, DATA_K1, 128'h0, 1'b0);
    req_a("wr_k2", 1'b1, 15'd31998, DATA_K2, 128'h0, 1'b0);
    req_a("wr_a", 1'b1, 15'h0010, DATA_A, 128'h0, 1'b0);
    req_a("rd_a13", 1'b0, 15'h0013, 128'h0, DATA_A, 1'b0);
    req_a("rd_last", 1'b0, 15'd31999, 128'h0, DATA_K2, 1'b0);
    req_a("rd_oor", 1'b0, 15'd32000, 128'h0, 128'h0, 1'b1);
    req_a("wr_oor", 1'b1, 15'd32004, DATA_K1, 128'h0, 1'b1);
    req_a("rd_a10", 1'b0, 15'h0010, 128'h0, DATA_A, 1'b0);
    req_a("rd_k1", 1'b0, 15'h0020, 128'h0, DATA_K1, 1'b0);

    // back-to-back: req_valid held high, address changes every cycle
    pat[0] = 15'h0010; pat[1] = 15'h0021; pat[2] = 15'd32000;
    pat[3] = 15'h0013; pat[4] = 15'd31997;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b0; a_addr = pat[c % 5];
      chk($sformatf("b2b ready c%0d", c), a_ready, 128'(c % 4 == 0));
      if (c % 4 == 0) acc_addr = pat[c % 5];
      @(posedge clk); #1;
      chk($sformatf("b2b rv c%0d", c), a_rv, 128'(c % 4 == 2));
      if (c % 4 == 2) begin
        m = model_a(acc_addr);
        chk($sformatf("b2b err c%0d", c), a_err, 128'(m[128]));
        chk($sformatf("b2b rd c%0d", c), a_rd, m[127:0]);
      end
    end
    @(negedge clk);
    a_valid = 1'b0;

    // reset one cycle after accepting a write: aborted
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 15'h0020; a_wr = '1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("abort busy", a_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort ready", a_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort rv%0d", k), a_rv, 0);
    end
    req_a("abort rd", 1'b0, 15'h0020, 128'h0, DATA_K1, 1'b0);

    // reset coinciding with the commit edge: reset wins
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_wr = '1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("coinc rv", a_rv, 0);
    chk("coinc rd_cleared", a_rd, 0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("coinc rv%0d", k), a_rv, 0);
    end
    req_a("coinc rd", 1'b0, 15'h0010, 128'h0, DATA_A, 1'b0);

    // DUT B: LATENCY 1, 8 words of 16 bits
    req_b("b_wr", 1'b1, 15'h0010, DATA_B, 128'h0, 1'b0);
    req_b("b_rd17", 1'b0, 15'h0017, 128'h0, DATA_B, 1'b0);
    req_b("b_oor", 1'b0, 15'd32007, 128'h0, 128'h0, 1'b1);
    req_b("b_rd13", 1'b0, 15'h0013, 128'h0, DATA_B, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
